uart_tx_ctrl: RTL and testbench
===============================

// Module: uart_tx_ctrl
// PURPOSE
//  - Byte-wide asynchronous serial transmitter: 8 data bits, LSB first, 1 start, 1 stop (8N1).
//  - Sits between the message-sequencing FSM and output pad uo_out[0].
//  - The FSM pulses a send request with a byte, waits for the done pulse, then sends the next byte.
// PARAMETERS
//  - CLK_FREQ_HZ   10_000_000  system clock frequency
//  - BAUD_RATE     115_200     line rate
//  - CLKS_PER_BIT  CLK_FREQ_HZ/BAUD_RATE (=86)  cycles per bit; must be >= 2
// PORTS
//  - clk           in   1  single system clock, all logic on posedge
//  - rst_n         in   1  reset: synchronous, active-low (already-synchronized reset from top)
//  - uart_tx_send  in   1  send request; sampled each posedge
//  - uart_tx_data  in   8  byte to send; captured with an accepted request
//  - uart_tx_done  out  1  one-cycle pulse: frame (incl. stop bit) completed
//  - uart_tx_busy  out  1  high while a frame is in progress
//  - uart_txd      out  1  serial line, idle high
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge): uart_txd=1, busy=0, done=0, FSM=IDLE, counters=0; aborts any frame.
//  - FSM states: IDLE -> START -> DATA -> STOP -> IDLE.
//  - IDLE: txd=1. When send=1: latch data into shift reg, enter START, busy=1 at that same edge.
//  - START: txd=0 for CLKS_PER_BIT cycles.
//  - DATA: txd=shift[0] for CLKS_PER_BIT cycles per bit; shift right; 3-bit index 0..7, 8 bits total.
//  - STOP: txd=1 for CLKS_PER_BIT cycles; at end -> IDLE, busy=0 and done=1 for one cycle, same edge.
//  - Latency: txd falls 1 cycle after send sampled; frame = 10*CLKS_PER_BIT cycles; done pulses
//    the cycle after the last stop-bit cycle.
//  - send while busy=1 ignored (no queueing, data not re-latched). send in the done cycle is accepted.
//  - Data changes after acceptance do not affect the frame in flight.
//  - Bit counter: unsigned, width clog2(CLKS_PER_BIT); compares to CLKS_PER_BIT-1, then wraps to 0.
//  - txd registered (glitch-free); done/busy registered.
// CONFIGURATION
//  - Macro UART_TX_PARITY_EN.
//  - Defined: PARITY state between DATA and STOP, one bit of even parity (XOR of 8 data bits);
//    frame = 11*CLKS_PER_BIT cycles.
//  - Undefined: pure 8N1, 10*CLKS_PER_BIT cycles; no parity logic present.
// STRUCTURE
//  - Package uart_pkg: state encoding localparams (IDLE, START, DATA, PARITY, STOP),
//    DATA_BITS=8, default CLK_FREQ_HZ/BAUD_RATE.
//  - One sub-module uart_baud_gen: counter producing a one-cycle bit_tick every CLKS_PER_BIT cycles;
//    restarted on frame start.
//  - Top: FSM, shift register, bit index, output registers.
// TESTING
//  - Reset: hold rst_n=0 4 cycles, mid-frame too -> txd=1, busy=0, done=0 next edge.
//  - Send 0x42 -> line reads 0,0,1,0,0,0,0,1,0,1 (start, LSB first, stop), each bit 86 cycles;
//    done one cycle at cycle 861.
//  - Back-to-back: send 0x61 on done cycle -> next start bit immediately, no idle gap beyond 1 cycle.
//  - Send re-asserted with 0xFF while busy -> ignored; frame carries original byte, single done pulse.
//  - Message "Baptiste !\n" via 11 sends -> decoder receives exact bytes, 11 done pulses.
//  - With UART_TX_PARITY_EN: send 0x07 -> parity bit 1; send 0x03 -> 0; done at 11*86+1 cycles.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and defaults for the 8N1 UART transmitter.
// Optional even-parity bit is enabled by defining UART_TX_PARITY_EN.
package uart_pkg;

  localparam int DATA_BITS           = 8;
  localparam int CLK_FREQ_HZ_DEFAULT = 10_000_000;
  localparam int BAUD_RATE_DEFAULT   = 115_200;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

endpackage

// File: rtl/uart_tx_ctrl_if.sv
// Handshake and serial-line bundle between the message sequencer and the UART transmitter.
interface uart_tx_ctrl_if;
  import uart_pkg::*;

  logic                 uart_tx_send;
  logic [DATA_BITS-1:0] uart_tx_data;
  logic                 uart_tx_done;
  logic                 uart_tx_busy;
  logic                 uart_txd;

  modport master (
    output uart_tx_send, uart_tx_data,
    input  uart_tx_done, uart_tx_busy, uart_txd
  );

  modport slave (
    input  uart_tx_send, uart_tx_data,
    output uart_tx_done, uart_tx_busy, uart_txd
  );

endinterface

// File: rtl/uart_baud_gen.sv
// Bit-period timer: bit_tick pulses for one cycle every CLKS_PER_BIT cycles,
// with the phase realigned whenever restart is asserted (frame start).
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 86
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic bit_tick
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (restart || (cnt_q == LAST)) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign bit_tick = (cnt_q == LAST);

endmodule

// File: rtl/uart_tx_ctrl.sv
// Byte-wide asynchronous serial transmitter (8N1, LSB first, registered outputs).
// Defining UART_TX_PARITY_EN inserts one even-parity bit between data and stop.
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int CLK_FREQ_HZ  = CLK_FREQ_HZ_DEFAULT,
  parameter int BAUD_RATE    = BAUD_RATE_DEFAULT,
  parameter int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE
) (
  input logic           clk,
  input logic           rst_n,
  uart_tx_ctrl_if.slave tx_if
);

  tx_state_e            state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [2:0]           idx_q, idx_d;
  logic                 txd_q, txd_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 accept;
  logic                 bit_tick;
`ifdef UART_TX_PARITY_EN
  logic                 parity_q, parity_d;
`endif

  assign accept = (state_q == IDLE) && tx_if.uart_tx_send;

  uart_baud_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .restart  (accept),
    .bit_tick (bit_tick)
  );

  // NOTE: every variable gets a default before the case so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    idx_d    = idx_q;
    txd_d    = txd_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
`endif
    case (state_q)
      IDLE: begin
        txd_d = 1'b1;
        if (tx_if.uart_tx_send) begin
          shift_d  = tx_if.uart_tx_data;
          idx_d    = '0;
          txd_d    = 1'b0;
          busy_d   = 1'b1;
          state_d  = START;
`ifdef UART_TX_PARITY_EN
          parity_d = ^tx_if.uart_tx_data;
`endif
        end
      end
      START: begin
        if (bit_tick) begin
          state_d = DATA;
          txd_d   = shift_q[0];
        end
      end
      DATA: begin
        if (bit_tick) begin
          if (idx_q == 3'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
            txd_d   = parity_q;
`else
            state_d = STOP;
            txd_d   = 1'b1;
`endif
          end else begin
            idx_d   = idx_q + 3'd1;
            shift_d = shift_q >> 1;
            txd_d   = shift_q[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_tick) begin
          state_d = STOP;
          txd_d   = 1'b1;
        end
      end
`endif
      STOP: begin
        if (bit_tick) begin
          state_d = IDLE;
          txd_d   = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        txd_d   = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  // NOTE: the shift register is reset too; it is a handful of flops, not a memory array.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      idx_q    <= '0;
      txd_q    <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      idx_q    <= idx_d;
      txd_q    <= txd_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign tx_if.uart_txd     = txd_q;
  assign tx_if.uart_tx_busy = busy_q;
  assign tx_if.uart_tx_done = done_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Scoreboard bench for uart_tx_ctrl: a line monitor decodes frames and compares them
// against bytes queued by the stimulus process. Honours UART_TX_PARITY_EN.
module tb_uart_tx_ctrl;

  localparam int CPB = 86;  // 10 MHz / 115200 baud, truncated
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  typedef struct {
    logic [7:0] data;
    int         start_cyc;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_vec;
  int   n_miss;
  int   n_done;
  int   n_accepted;
  logic prev_done;
  exp_t exp_q[$];

  uart_tx_ctrl_if ifc ();

  uart_tx_ctrl #(
    .CLK_FREQ_HZ (10_000_000),
    .BAUD_RATE   (115_200)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .tx_if (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference line level for position bit_pos of the frame carrying byte b.
  function automatic logic model_level(input logic [7:0] b, input int bit_pos);
    int ones;
    if (bit_pos == 0) return 1'b0;
    if (bit_pos <= 8) return ((b >> (bit_pos - 1)) & 8'h01) != 8'h00;
`ifdef UART_TX_PARITY_EN
    if (bit_pos == 9) begin
      ones = 0;
      for (int k = 0; k < 8; k++) ones += (b >> k) & 1;
      return (ones % 2) == 1;
    end
`endif
    return 1'b1;
  endfunction

  // Done pulse counter; a pulse must never last two cycles.
  initial begin
    n_done    = 0;
    prev_done = 1'b0;
  end
  always @(negedge clk) begin
    if (rst_n === 1'b1 && ifc.uart_tx_done === 1'b1) begin
      n_done <= n_done + 1;
      check("done_single", {31'd0, prev_done}, 0);
    end
    prev_done <= (ifc.uart_tx_done === 1'b1);
  end

  // Line monitor / scoreboard.
  initial begin : monitor
    exp_t       e;
    bit         have;
    bit         aborted;
    bit         bad_line;
    bit         bad_busy;
    logic [7:0] rx;
    int         bit_pos;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) begin
        exp_q.delete();
        continue;
      end
      if (ifc.uart_txd === 1'b0) begin
        have = (exp_q.size() > 0);
        if (have) begin
          e = exp_q.pop_front();
          check("start_cycle", cyc, e.start_cyc);
        end else begin
          e.data      = 8'h00;
          e.start_cyc = cyc;
          check("unexpected_frame", 1, 0);
        end
        rx       = 8'h00;
        bad_line = 1'b0;
        bad_busy = 1'b0;
        aborted  = 1'b0;
        for (int i = 0; i < NB * CPB; i++) begin
          if (i > 0) @(negedge clk);
          if (rst_n !== 1'b1) begin
            aborted = 1'b1;
            break;
          end
          bit_pos = i / CPB;
          if (ifc.uart_txd !== model_level(e.data, bit_pos)) bad_line = 1'b1;
          if (ifc.uart_tx_busy !== 1'b1) bad_busy = 1'b1;
          if ((i % CPB) == CPB / 2 && bit_pos >= 1 && bit_pos <= 8) rx[bit_pos-1] = ifc.uart_txd;
          if ((i % CPB) == CPB - 1 && have) begin
            check($sformatf("bit%0d_line", bit_pos), {31'd0, bad_line}, 0);
            check($sformatf("bit%0d_busy", bit_pos), {31'd0, bad_busy}, 0);
            bad_line = 1'b0;
            bad_busy = 1'b0;
          end
        end
        if (aborted) begin
          exp_q.delete();
          continue;
        end
        @(negedge clk);
        if (rst_n !== 1'b1) begin
          exp_q.delete();
          continue;
        end
        if (have) begin
          check("rx_byte", rx, e.data);
          check("done_pulse", ifc.uart_tx_done, 1);
          check("busy_clear", ifc.uart_tx_busy, 0);
          check("line_idle_after_stop", ifc.uart_txd, 1);
        end
      end else if (exp_q.size() > 0 && cyc > exp_q[0].start_cyc) begin
        check("missing_start", cyc, exp_q[0].start_cyc);
        void'(exp_q.pop_front());
      end
    end
  end

  // Called at a falling edge; the request is sampled at the next rising edge.
  task automatic issue(input logic [7:0] b);
    exp_t e;
    #1;
    ifc.uart_tx_send = 1'b1;
    ifc.uart_tx_data = b;
    e.data      = b;
    e.start_cyc = cyc + 1;
    exp_q.push_back(e);
    n_accepted++;
    @(negedge clk);
    #1;
    ifc.uart_tx_send = 1'b0;
    ifc.uart_tx_data = 8'($urandom);
  endtask

  // Returns at the falling edge where done is seen high.
  task automatic wait_done();
    bit got;
    got = 1'b0;
    for (int k = 0; k < NB * CPB + 20; k++) begin
      @(negedge clk);
      if (ifc.uart_tx_done === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) check("done_timeout", 0, 1);
  endtask

  task automatic check_reset_outputs();
    check("rst_txd", ifc.uart_txd, 1);
    check("rst_busy", ifc.uart_tx_busy, 0);
    check("rst_done", ifc.uart_tx_done, 0);
  endtask

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d vectors applied", n_vec);
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    string msg;
    int    drain;
    n_vec      = 0;
    n_miss     = 0;
    n_accepted = 0;
    msg        = "Baptiste !\n";
    rst_n            = 1'b0;
    ifc.uart_tx_send = 1'b0;
    ifc.uart_tx_data = 8'h00;

    @(posedge clk);
    @(negedge clk);
    check_reset_outputs();
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Single frame, then one sent in the done cycle.
    issue(8'h42);
    wait_done();
    issue(8'h61);

    // Request with a different byte while busy must be ignored.
    repeat (20) @(negedge clk);
    #1;
    ifc.uart_tx_send = 1'b1;
    ifc.uart_tx_data = 8'hFF;
    repeat (5) @(negedge clk);
    #1 ifc.uart_tx_send = 1'b0;
    wait_done();
    repeat (3) @(negedge clk);

    // Reset in the middle of a frame aborts it.
    issue(8'hC3);
    repeat (300) @(negedge clk);
    #1 rst_n = 1'b0;
    n_accepted--;
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs();
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Message sent back-to-back, sequencer style.
    for (int i = 0; i < msg.len(); i++) begin
      issue(msg[i]);
      wait_done();
    end

    // Parity-relevant bytes and random traffic with short random gaps.
    repeat (2) @(negedge clk);
    issue(8'h07);
    wait_done();
    issue(8'h03);
    wait_done();
    for (int i = 0; i < 8; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      issue(8'($urandom));
      wait_done();
    end

    drain = 0;
    while (exp_q.size() > 0 && drain < NB * CPB + 20) begin
      @(negedge clk);
      drain++;
    end
    repeat (5) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    check("done_count", n_done, n_accepted);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
